// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: one single-bit LSL/LSR/ROL/ASR step per clock
// until the latched amount is exhausted, then a one-cycle done pulse.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CNT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             cout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_LSL;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dout_d  = din;
          cout_d  = 1'b0;
          cnt_d   = amt;
          mode_d  = mode;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        case (mode_q)
          MODE_LSL: begin
            cout_d = dout_q[WIDTH-1];
            dout_d = {dout_q[WIDTH-2:0], 1'b0};
          end
          MODE_LSR: begin
            cout_d = dout_q[0];
            dout_d = {1'b0, dout_q[WIDTH-1:1]};
          end
          MODE_ROL: begin
            cout_d = dout_q[WIDTH-1];
            dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
          end
          default: begin
            cout_d = dout_q[0];
            dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        // Last step is taken on the edge where one step remains.
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign dout = dout_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against a closed-form shift model.
module tb_shift_sequencer;
  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  din   = '0;
  logic [CW-1:0] amt   = '0;
  logic [1:0]    mode  = '0;
  logic          busy, done, cout;
  logic [W-1:0]  dout;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] trace [0:63];

  shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .amt(amt),
    .mode(mode), .busy(busy), .done(done), .dout(dout), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Closed-form result of n single-bit shifts, computed with whole-word arithmetic.
  function automatic void model(input logic [7:0] d, input int n, input logic [1:0] m,
                                output logic [7:0] r, output logic c);
    int x, sx, k;
    x  = int'(d);
    sx = int'($signed(d));
    r  = d;
    c  = 1'b0;
    case (m)
      2'b00: begin
        r = 8'(x << n);
        c = (n == 0) ? 1'b0 : 1'((x << n) >> 8);
      end
      2'b01: begin
        r = 8'(x >> n);
        c = (n == 0) ? 1'b0 : 1'(x >> (n - 1));
      end
      2'b10: begin
        k = n % 8;
        r = (k == 0) ? d : 8'((x << k) | (x >> (8 - k)));
        c = (n == 0) ? 1'b0 : r[0];
      end
      default: begin
        r = 8'(sx >>> n);
        c = (n == 0) ? 1'b0 : 1'(sx >>> (n - 1));
      end
    endcase
  endfunction

  // Launch one operation and observe it; cycle 1 is the cycle after the accepting edge.
  task automatic do_op(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m,
                       input bit hold, output int bcnt, output int done_at,
                       output logic [7:0] r, output logic c);
    bcnt = 0;
    done_at = -1;
    r = '0;
    c = 1'b0;
    @(negedge clk);
    start = 1'b1; din = d; amt = a; mode = m;
    @(negedge clk);
    start = hold;
    din = W'($urandom); amt = CW'($urandom); mode = 2'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      trace[cyc] = dout;
      if (busy) bcnt++;
      if (done) begin
        done_at = cyc;
        r = dout;
        c = cout;
        break;
      end
      @(negedge clk);
    end
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dout); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
  endtask

  task automatic test_lsl_basic();
    int b, da; logic [7:0] r; logic c;
    do_op(8'h01, 4'd1, 2'b00, 1'b0, b, da, r, c);
    checks++; if (b !== 1) begin errors++; $display("FAIL lsl1_busy: got %0d want 1", b); end
    checks++; if (da !== 2) begin errors++; $display("FAIL lsl1_done_cycle: got %0d want 2", da); end
    checks++; if (r !== 8'h02) begin errors++; $display("FAIL lsl1_dout: got %h want 02", r); end
    checks++; if (c !== 1'b0) begin errors++; $display("FAIL lsl1_cout: got %b want 0", c); end
  endtask

  task automatic test_walking_one();
    int b, da; logic [7:0] r, d; logic c;
    for (int i = 0; i < 8; i++) begin
      d = 8'(1 << i);
      do_op(d, 4'd1, 2'b00, 1'b0, b, da, r, c);
      checks++; if (r !== 8'(d << 1)) begin errors++; $display("FAIL walk_dout[%0d]: got %h want %h", i, r, 8'(d << 1)); end
      checks++; if (c !== (i == 7)) begin errors++; $display("FAIL walk_cout[%0d]: got %b want %b", i, c, (i == 7)); end
    end
  endtask

  task automatic test_rol_three();
    int b, da; logic [7:0] r, er; logic c, ec;
    do_op(8'h81, 4'd3, 2'b10, 1'b0, b, da, r, c);
    checks++; if (b !== 3) begin errors++; $display("FAIL rol_busy: got %0d want 3", b); end
    checks++; if (da !== 4) begin errors++; $display("FAIL rol_done_cycle: got %0d want 4", da); end
    for (int k = 1; k <= 3; k++) begin
      model(8'h81, k, 2'b10, er, ec);
      checks++; if (trace[k+1] !== er) begin errors++; $display("FAIL rol_step%0d: got %h want %h", k, trace[k+1], er); end
    end
    checks++; if (r !== 8'h0C || c !== 1'b0) begin errors++; $display("FAIL rol_final: got %h/%b want 0c/0", r, c); end
  endtask

  task automatic test_asr_lsr();
    int b, da; logic [7:0] r; logic c;
    do_op(8'h90, 4'd2, 2'b11, 1'b0, b, da, r, c);
    checks++; if (trace[2] !== 8'hC8) begin errors++; $display("FAIL asr_step1: got %h want c8", trace[2]); end
    checks++; if (r !== 8'hE4 || c !== 1'b0) begin errors++; $display("FAIL asr_final: got %h/%b want e4/0", r, c); end
    do_op(8'hFF, 4'd12, 2'b01, 1'b0, b, da, r, c);
    checks++; if (b !== 12) begin errors++; $display("FAIL lsr_over_busy: got %0d want 12", b); end
    checks++; if (r !== 8'h00 || c !== 1'b0) begin errors++; $display("FAIL lsr_over_final: got %h/%b want 00/0", r, c); end
  endtask

  task automatic test_amt_zero();
    int b, da; logic [7:0] r; logic c;
    do_op(8'h5A, 4'd0, 2'b00, 1'b0, b, da, r, c);
    checks++; if (b !== 0) begin errors++; $display("FAIL amt0_busy: got %0d want 0", b); end
    checks++; if (da !== 1) begin errors++; $display("FAIL amt0_done_cycle: got %0d want 1", da); end
    checks++; if (r !== 8'h5A || c !== 1'b0) begin errors++; $display("FAIL amt0_result: got %h/%b want 5a/0", r, c); end
  endtask

  task automatic test_start_ignored();
    int b, da; logic [7:0] r; logic c;
    do_op(8'h01, 4'd4, 2'b00, 1'b1, b, da, r, c);
    checks++; if (b !== 4 || da !== 5) begin errors++; $display("FAIL ign_timing: got busy=%0d done@%0d want 4/5", b, da); end
    checks++; if (r !== 8'h10) begin errors++; $display("FAIL ign_dout: got %h want 10", r); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0 || dout !== 8'h10) begin
      errors++; $display("FAIL ign_no_queue: got busy=%b done=%b dout=%h want 0/0/10", busy, done, dout);
    end
  endtask

  task automatic test_reset_mid();
    int b, da, nb; logic [7:0] r; logic c; bit saw;
    @(negedge clk);
    start = 1'b1; din = 8'hFF; amt = 4'd10; mode = 2'b00;
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      if (busy) nb++;
      if (nb < 4) @(negedge clk);
    end
    checks++; if (nb !== 4) begin errors++; $display("FAIL rstmid_busy_reached: got %0d want 4", nb); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got dout=%h cout=%b busy=%b done=%b want 00/0/0/0", dout, cout, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_abandoned: got activity=%b want 0", saw); end
    do_op(8'h03, 4'd1, 2'b00, 1'b0, b, da, r, c);
    checks++; if (r !== 8'h06 || da !== 2) begin errors++; $display("FAIL rstmid_recover: got %h done@%0d want 06 done@2", r, da); end
  endtask

  task automatic test_random();
    int b, da; logic [7:0] r, d, er; logic c, ec; logic [3:0] a; logic [1:0] m;
    for (int i = 0; i < 30; i++) begin
      d = 8'($urandom);
      a = 4'($urandom_range(0, 15));
      m = 2'($urandom);
      model(d, int'(a), m, er, ec);
      do_op(d, a, m, 1'b0, b, da, r, c);
      checks++; if (r !== er || c !== ec) begin
        errors++; $display("FAIL rand_result[%0d] d=%h a=%0d m=%0d: got %h/%b want %h/%b", i, d, a, m, r, c, er, ec);
      end
      checks++; if (b !== int'(a) || da !== int'(a) + 1) begin
        errors++; $display("FAIL rand_timing[%0d]: got busy=%0d done@%0d want %0d/%0d", i, b, da, a, a + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lsl_basic();
    test_walking_one();
    test_rol_three();
    test_asr_lsr();
    test_amt_zero();
    test_start_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
